// File: rtl/display_mode_engine.sv
// Registered display-mode engine: captures mode/switch data on load and holds packed hex digits.
// Product mode runs a 4-cycle shift-add; count mode runs a divided free-running 16-bit counter.
module display_mode_engine #(
    parameter int          NUM_DIGITS = 4,
    parameter int          IN_W       = 14,
    parameter logic [15:0] ID_VALUE   = 16'h6496,
    parameter int          TICK_DIV   = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              mode_sel_i,
    input  logic [IN_W-1:0]         slider_i,
    input  logic                    load_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    busy_o,
    output logic                    valid_o
);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam int DIV_W = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       x_q, x_d, y_q, y_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       acc_q, acc_d;
    logic [1:0]       it_q, it_d;

    logic [5:0] top6;
    logic [4:0] sum5;

    assign top6 = slider_i[IN_W-1 -: 6];
    assign sum5 = {1'b0, slider_i[7:4]} + {1'b0, slider_i[3:0]};

    // Only the nibbles the multiplier consumes are kept; the other modes finish at the load edge.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dig_d   = dig_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        acc_d   = acc_q;
        it_d    = it_q;

        if (state_q == S_MUL) begin
            acc_d = acc_q + (y_q[it_q] ? (8'({4'b0000, x_q}) << it_q) : 8'd0);
            it_d  = it_q + 2'd1;
            if (it_q == 2'd3) begin
                dig_d   = DW'({x_q, y_q, acc_d});
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end else if (load_i) begin
            x_d     = slider_i[7:4];
            y_d     = slider_i[3:0];
            valid_d = 1'b1;
            state_d = S_IDLE;
            case (mode_sel_i)
                3'd0: dig_d = DW'(ID_VALUE);
                3'd1: dig_d = DW'(slider_i);
                3'd2: dig_d = DW'({2'b00, top6, 1'b0, top6, 1'b0});
                3'd3: dig_d = DW'({slider_i[7:0], 3'b000, sum5});
                3'd4: begin
                    state_d = S_MUL;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    acc_d   = 8'd0;
                    it_d    = 2'd0;
                end
                3'd5: begin
                    state_d = S_RUN;
                    cnt_d   = 16'd0;
                    div_d   = '0;
                    dig_d   = '0;
                end
                default: dig_d = '0;
            endcase
        end else if (state_q == S_RUN) begin
            if (div_q == DIV_W'(TICK_DIV - 1)) begin
                div_d = '0;
                cnt_d = cnt_q + 16'd1;
                dig_d = DW'(cnt_d);
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dig_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            acc_q   <= '0;
            it_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dig_q   <= dig_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            it_q    <= it_d;
        end
    end

    assign digits_o = dig_q;
    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
endmodule

// File: tb/tb_display_mode_engine.sv
// Bench for display_mode_engine: vector table, hand sequences for multi-cycle cases, random vs model.
module tb_display_mode_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  mode_sel = '0;
    logic [13:0] slider = '0;
    logic        load = 1'b0;
    logic [15:0] dig_a;
    logic [23:0] dig_b;
    logic        busy_a, valid_a, busy_b, valid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display_mode_engine #(.NUM_DIGITS(4), .IN_W(14), .ID_VALUE(16'h6496), .TICK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode_sel_i(mode_sel), .slider_i(slider), .load_i(load),
        .digits_o(dig_a), .busy_o(busy_a), .valid_o(valid_a));

    display_mode_engine #(.NUM_DIGITS(6), .IN_W(14), .ID_VALUE(16'h6496), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode_sel_i(mode_sel), .slider_i(slider), .load_i(load),
        .digits_o(dig_b), .busy_o(busy_b), .valid_o(valid_b));

    typedef struct {
        logic [2:0]  mode;
        logic [13:0] sl;
        logic [15:0] ea;
        logic [23:0] eb;
    } vec_t;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the capturing edge.
    task automatic do_load(input logic [2:0] m, input logic [13:0] s);
        mode_sel = m;
        slider   = s;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    // Display content derived from the mode rules with plain integer arithmetic.
    function automatic logic [23:0] model(input int m, input int s);
        int x, y, a;
        x = (s / 16) % 16;
        y = s % 16;
        a = (s / 256) % 64;
        case (m)
            0: return 24'h006496;
            1: return 24'(s);
            2: return 24'((a / 16) * 4096 + (a % 16) * 256 + 2 * a);
            3: return 24'(x * 4096 + y * 256 + x + y);
            4: return 24'(x * 4096 + y * 256 + x * y);
            default: return 24'h0;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   n;
        logic found;

        tbl[0] = '{3'd0, 14'h0000, 16'h6496, 24'h006496};
        tbl[1] = '{3'd1, 14'h2ABC, 16'h2ABC, 24'h002ABC};
        tbl[2] = '{3'd2, 14'h3F00, 16'h3F7E, 24'h003F7E};
        tbl[3] = '{3'd3, 14'h00FF, 16'hFF1E, 24'h00FF1E};
        tbl[4] = '{3'd3, 14'h0099, 16'h9912, 24'h009912};
        tbl[5] = '{3'd6, 14'h3FFF, 16'h0000, 24'h000000};
        tbl[6] = '{3'd2, 14'h0400, 16'h0408, 24'h000408};
        tbl[7] = '{3'd7, 14'h1234, 16'h0000, 24'h000000};
        tbl[8] = '{3'd1, 14'h3FFF, 16'h3FFF, 24'h003FFF};

        // Reset state, then idle with wiggling inputs and no load.
        cyc(3);
        chk("rst_digits", dig_a, 24'h0);
        chk("rst_busy", busy_a, 24'h0);
        chk("rst_valid", valid_a, 24'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            mode_sel = 3'($urandom_range(0, 7));
            slider   = 14'($urandom);
            cyc(1);
            if (i % 20 == 0) chk("idle_hold", {dig_a, busy_a, valid_a}, 24'h0);
        end

        for (int i = 0; i < 9; i++) begin
            do_load(tbl[i].mode, tbl[i].sl);
            chk($sformatf("tbl%0d_a", i), dig_a, tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), dig_b, tbl[i].eb);
            chk($sformatf("tbl%0d_vb", i), {valid_a, busy_a}, 24'h2);
        end

        // Async reset mid-cycle after a result is shown.
        do_load(3'd0, 14'h0);
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        #1;
        chk("async_rst", {dig_a, busy_a, valid_a}, 24'h0);
        cyc(1);
        rst_n = 1'b1;

        // Slider change without load has no effect.
        do_load(3'd1, 14'h2ABC);
        slider = 14'h0001;
        cyc(3);
        chk("no_load_hold", dig_a, 24'h2ABC);

        // Product: 4 busy cycles, prior digits held, load during busy ignored.
        do_load(3'd4, 14'h00FD);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mul_busy%0d", i), {dig_a, busy_a, valid_a}, {16'h2ABC, 2'b10});
            if (i == 2) begin
                mode_sel = 3'd0;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            cyc(1);
        end
        chk("mul_done", {dig_a, busy_a, valid_a}, {16'hFDC3, 2'b01});
        cyc(2);
        chk("mul_ignored_load", dig_a, 24'hFDC3);

        // Reset during product aborts with no partial result.
        do_load(3'd4, 14'h0037);
        cyc(1);
        #2 rst_n = 1'b0;
        #1 chk("mul_abort", {dig_a, busy_a, valid_a}, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(6);
        chk("mul_abort_after", {dig_a, busy_a, valid_a}, 24'h0);

        // Count mode: value equals completed divider periods since the load edge.
        do_load(3'd5, 14'h0);
        for (int k = 1; k <= 13; k++) begin
            chk($sformatf("cnt_k%0d", k), {dig_a, busy_a, valid_a}, {16'((k - 1) / 4), 2'b01});
            cyc(1);
        end
        do_load(3'd5, 14'h0);
        chk("cnt_reload0", dig_a, 24'h0);
        cyc(4);
        chk("cnt_reload1", dig_a, 24'h1);

        // Counter wrap near the top of range.
        force dut_a.cnt_q = 16'hFFFE;
        #1 release dut_a.cnt_q;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(1);
            if (dig_a == 16'hFFFF) found = 1'b1;
        end
        chk("wrap_reach_ffff", found, 24'h1);
        cyc(3);
        chk("wrap_hold_ffff", dig_a, 24'hFFFF);
        cyc(1);
        chk("wrap_to_0", dig_a, 24'h0);
        cyc(4);
        chk("wrap_to_1", dig_a, 24'h1);

        // Leave count mode with a hex load; counter must stop.
        do_load(3'd1, 14'h1234);
        chk("run_exit", dig_a, 24'h1234);
        cyc(10);
        chk("run_exit_hold", {dig_a, busy_a, valid_a}, {16'h1234, 2'b01});

        // Random loads against the model.
        for (int r = 0; r < 40; r++) begin
            int m, s;
            logic [23:0] e;
            m = $urandom_range(0, 6);
            if (m >= 5) m = m + 1;
            s = int'($urandom_range(0, 16383));
            e = model(m, s);
            do_load(3'(m), 14'(s));
            if (m == 4) begin
                n = 1;
                while (busy_a && n < 10) begin
                    cyc(1);
                    n++;
                end
                chk($sformatf("rnd%0d_lat", r), 24'(n), 24'd5);
            end
            chk($sformatf("rnd%0d_a m%0d s%h", r, m, s), dig_a, {8'h0, e[15:0]});
            chk($sformatf("rnd%0d_b m%0d s%h", r, m, s), dig_b, e);
            chk($sformatf("rnd%0d_v", r), {valid_a, busy_a}, 24'h2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
